// File: rtl/cpu_dbg_pkg.sv
// Shared debug-block definitions: capture state encoding, trigger modes and
// the field layout of a packed trace entry {pc, instr, wb_data}.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_POST    = 2'd2,
    ST_READOUT = 2'd3
  } state_e;

  localparam logic [1:0] TRIG_PC    = 2'b00;
  localparam logic [1:0] TRIG_INSTR = 2'b01;
  localparam logic [1:0] TRIG_BOTH  = 2'b10;
  localparam logic [1:0] TRIG_IMM   = 2'b11;

  localparam int WB_LSB = 0;

  function automatic int instr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int pc_lsb(input int instr_w, input int data_w);
    return instr_w + data_w;
  endfunction

endpackage

// File: rtl/trace_buffer_if.sv
// Retired-instruction sample bus plus the trace readout port.
interface trace_buffer_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8,
  parameter int DATA_W  = 8
);
  localparam int ENTRY_W = PC_W + INSTR_W + DATA_W;

  logic               retire;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  wb_data;

  // Readout: an entry transfers on a cycle with rd_valid && rd_ready; while
  // rd_valid is high and rd_ready low, rd_valid and rd_data hold steady.
  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;

  modport master (
    output retire, pc, instr, wb_data, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  retire, pc, instr, wb_data, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/trace_mem.sv
// Trace storage: synchronous write, asynchronous read, contents never reset.
module trace_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 24,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/trace_buffer.sv
// Triggered instruction trace: records retired instructions into a circular
// buffer around a trigger point, then drains oldest-first over a handshake.
module trace_buffer
  import cpu_dbg_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic [1:0]         trig_mode,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [INSTR_W-1:0] trig_instr,
  input  logic [AW-1:0]      post_count,
  trace_buffer_if.slave      bus,
  output logic [1:0]         state,
  output logic               triggered,
  output logic [AW:0]        count,
  output logic               done
);
  localparam int ENTRY_W   = PC_W + INSTR_W + DATA_W;
  localparam int PC_LSB    = pc_lsb(INSTR_W, DATA_W);
  localparam int INSTR_LSB = instr_lsb(DATA_W);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  state_e        r_state, w_next_state;
  logic [AW-1:0] r_wptr, r_rptr, r_remaining;
  logic [AW:0]   r_count;
  logic          r_triggered, r_done;

  logic               w_mode_hit, w_trig, w_we, w_xfer, w_rd_valid, w_to_readout;
  logic [AW-1:0]      w_wptr_inc;
  logic [AW:0]        w_count_inc;
  logic [ENTRY_W-1:0] w_wdata, w_rdata;

  always_comb begin
    w_mode_hit = 1'b0;
    case (trig_mode)
      TRIG_PC:    w_mode_hit = (bus.pc == trig_pc);
      TRIG_INSTR: w_mode_hit = (bus.instr == trig_instr);
      TRIG_BOTH:  w_mode_hit = (bus.pc == trig_pc) && (bus.instr == trig_instr);
      default:    w_mode_hit = 1'b1;
    endcase
  end

  // A concurrent arm restarts the capture, so that cycle's retire is dropped.
  assign w_we   = (r_state == ST_ARMED || r_state == ST_POST) && bus.retire && !arm;
  assign w_trig = (r_state == ST_ARMED) && w_we && w_mode_hit;
  assign w_xfer = w_rd_valid && bus.rd_ready;

  assign w_wptr_inc  = r_wptr + PTR_ONE;
  assign w_count_inc = (r_count == CNT_FULL) ? r_count : r_count + CNT_ONE;

  always_comb begin
    w_wdata = '0;
    w_wdata[PC_LSB +: PC_W]       = bus.pc;
    w_wdata[INSTR_LSB +: INSTR_W] = bus.instr;
    w_wdata[WB_LSB +: DATA_W]     = bus.wb_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (arm) w_next_state = ST_ARMED;
      ST_ARMED: begin
        if (arm)         w_next_state = ST_ARMED;
        else if (w_trig) w_next_state = (post_count == '0) ? ST_READOUT : ST_POST;
      end
      ST_POST: begin
        if (arm)                                 w_next_state = ST_ARMED;
        else if (w_we && r_remaining == PTR_ONE) w_next_state = ST_READOUT;
      end
      ST_READOUT: if (w_xfer && r_count == CNT_ONE) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  assign w_to_readout = (w_next_state == ST_READOUT) && (r_state != ST_READOUT);

  always_comb begin
    state      = r_state;
    w_rd_valid = (r_state == ST_READOUT) && (r_count != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (arm && r_state != ST_READOUT) begin
        r_wptr      <= '0;
        r_count     <= '0;
        r_remaining <= '0;
        r_triggered <= 1'b0;
      end else if (w_we) begin
        r_wptr  <= w_wptr_inc;
        r_count <= w_count_inc;
        if (w_trig) begin
          r_triggered <= 1'b1;
          r_remaining <= post_count;
        end else if (r_state == ST_POST) begin
          r_remaining <= r_remaining - PTR_ONE;
        end
        // Oldest entry sits count slots behind the post-write pointer.
        if (w_to_readout) r_rptr <= w_wptr_inc - w_count_inc[AW-1:0];
      end else if (w_xfer) begin
        r_rptr  <= r_rptr + PTR_ONE;
        r_count <= r_count - CNT_ONE;
        if (r_count == CNT_ONE) begin
          r_triggered <= 1'b0;
          r_done      <= 1'b1;
        end
      end
    end
  end

  trace_mem #(.DEPTH(DEPTH), .W(ENTRY_W)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

  assign bus.rd_valid = w_rd_valid;
  assign bus.rd_data  = w_rdata;
  assign triggered    = r_triggered;
  assign count        = r_count;
  assign done         = r_done;
endmodule

// File: tb/tb_trace_buffer.sv
// Scoreboard bench for trace_buffer (DEPTH=16, 8-bit fields).
module tb_trace_buffer;
  logic       clk = 1'b0;
  logic       reset;
  logic       arm;
  logic [1:0] trig_mode;
  logic [7:0] trig_pc, trig_instr;
  logic [3:0] post_count;
  logic [1:0] state;
  logic       triggered;
  logic [4:0] count;
  logic       done;

  trace_buffer_if #(.PC_W(8), .INSTR_W(8), .DATA_W(8)) bus ();

  trace_buffer #(.PC_W(8), .INSTR_W(8), .DATA_W(8), .DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .trig_mode  (trig_mode),
    .trig_pc    (trig_pc),
    .trig_instr (trig_instr),
    .post_count (post_count),
    .bus        (bus),
    .state      (state),
    .triggered  (triggered),
    .count      (count),
    .done       (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  int m_state = 0;
  int m_rem = 0;

  function automatic logic m_hit(input logic [7:0] p, input logic [7:0] i);
    case (trig_mode)
      2'b00:   return p == trig_pc;
      2'b01:   return i == trig_instr;
      2'b10:   return (p == trig_pc) && (i == trig_instr);
      default: return 1'b1;
    endcase
  endfunction

  // Drive one cycle of inputs at the falling edge and advance the model.
  task automatic drive_cycle(input logic a, input logic r, input logic [7:0] p,
                             input logic [7:0] i, input logic [7:0] w);
    @(negedge clk);
    arm = a; bus.retire = r; bus.pc = p; bus.instr = i; bus.wb_data = w;
    if (m_state == 1 || m_state == 2 || m_state == 0) begin
      if (a) begin
        m_state = 1;
        exp_q.delete();
      end else if (r && m_state != 0) begin
        exp_q.push_back({p, i, w});
        if (exp_q.size() > 16) void'(exp_q.pop_front());
        if (m_state == 1 && m_hit(p, i)) begin
          m_rem = int'(post_count);
          m_state = (m_rem == 0) ? 3 : 2;
        end else if (m_state == 2) begin
          m_rem--;
          if (m_rem == 0) m_state = 3;
        end
      end
    end
  endtask

  task automatic retire_pc(input logic [7:0] p, input logic [7:0] i);
    drive_cycle(1'b0, 1'b1, p, i, p ^ 8'hA5);
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  // Drain the readout; pat 0 = always ready, pat 1 = ready 1,0,0,1 repeating.
  task automatic drain(input int pat, input string name);
    int cyc = 0;
    int dcnt = 0;
    int k = 0;
    logic stalled = 1'b0;
    logic rdy;
    logic [23:0] held, exp;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) dcnt++;
      if (stalled) begin
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== held) begin
          errors++;
          $display("FAIL %s_hold: got valid=%b data=%h required valid=1 data=%h",
                   name, bus.rd_valid, bus.rd_data, held);
        end
      end
      if (bus.rd_valid !== 1'b1 && exp_q.size() == 0) break;
      rdy = (pat == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      k++;
      bus.rd_ready = rdy;
      if (bus.rd_valid === 1'b1) begin
        if (rdy) begin
          stalled = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_extra: got entry %h required none", name, bus.rd_data);
            break;
          end
          exp = exp_q.pop_front();
          if (bus.rd_data !== exp) begin
            errors++;
            $display("FAIL %s_data: got %h required %h", name, bus.rd_data, exp);
          end
        end else begin
          stalled = 1'b1;
          held = bus.rd_data;
        end
      end
    end
    bus.rd_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d entries never read, required 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (dcnt != 1) begin
      errors++;
      $display("FAIL %s_done: got %0d pulses required 1", name, dcnt);
    end
    checks++;
    if (state !== 2'd0 || count !== 5'd0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL %s_end: got state=%0d count=%0d trig=%b required 0 0 0",
               name, state, count, triggered);
    end
    m_state = 0;
  endtask

  task automatic check_capture(input string name, input logic [1:0] s, input logic [4:0] c,
                               input logic t);
    checks++;
    if (state !== s || count !== c || triggered !== t) begin
      errors++;
      $display("FAIL %s: got state=%0d count=%0d trig=%b required %0d %0d %b",
               name, state, count, triggered, s, c, t);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; arm = 1'b0; trig_mode = 2'b00; trig_pc = 8'h00; trig_instr = 8'h00;
    post_count = 4'd0; bus.retire = 1'b0; bus.pc = 8'h00; bus.instr = 8'h00;
    bus.wb_data = 8'h00; bus.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || count !== 5'd0 || bus.rd_valid !== 1'b0 ||
        triggered !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got state=%0d count=%0d valid=%b trig=%b done=%b required all 0",
               state, count, bus.rd_valid, triggered, done);
    end
    reset = 1'b1;
  endtask

  task automatic test_pc_trigger();
    trig_mode = 2'b00; trig_pc = 8'h04; trig_instr = 8'h31; post_count = 4'd2;
    drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int p = 0; p < 10; p++) begin
      retire_pc(8'(p), (p == 4) ? 8'h1A : 8'(p + 8'h30));
      if (p == 5) check_capture("pc_mid_post", 2'd2, 5'd5, 1'b1);
    end
    idle_cycle();
    check_capture("pc_readout", 2'd3, 5'd7, 1'b1);
    drain(0, "pc");
  endtask

  task automatic test_wrap();
    trig_mode = 2'b00; trig_pc = 8'h1C; post_count = 4'd3;
    drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int p = 0; p < 32; p++) retire_pc(8'(p), 8'(p + 8'h30));
    idle_cycle();
    check_capture("wrap_readout", 2'd3, 5'd16, 1'b1);
    drain(0, "wrap");
  endtask

  task automatic test_backpressure();
    trig_mode = 2'b01; trig_instr = 8'hC3; trig_pc = 8'h41; post_count = 4'd5;
    drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int p = 8'h40; p < 8'h50; p++) retire_pc(8'(p), (p == 8'h44) ? 8'hC3 : 8'(p));
    idle_cycle();
    check_capture("bp_readout", 2'd3, 5'd10, 1'b1);
    drain(1, "bp");
  endtask

  task automatic test_reset_mid_post();
    trig_mode = 2'b10; trig_pc = 8'h05; trig_instr = 8'h35; post_count = 4'd8;
    drive_cycle(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int p = 0; p < 11; p++) retire_pc(8'(p), (p == 2) ? 8'h35 : 8'(p + 8'h30));
    idle_cycle();
    check_capture("both_mid_post", 2'd2, 5'd11, 1'b1);
    reset = 1'b0;
    exp_q.delete();
    m_state = 0;
    @(negedge clk);
    checks++;
    if (state !== 2'd0 || count !== 5'd0 || bus.rd_valid !== 1'b0 || triggered !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got state=%0d count=%0d valid=%b trig=%b required 0 0 0 0",
               state, count, bus.rd_valid, triggered);
    end
    reset = 1'b1;
    idle_cycle();
    idle_cycle();
    checks++;
    if (state !== 2'd0 || bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got state=%0d valid=%b required 0 0", state, bus.rd_valid);
    end
  endtask

  task automatic test_immediate();
    trig_mode = 2'b11; post_count = 4'd0;
    drive_cycle(1'b1, 1'b1, 8'h77, 8'h11, 8'h22);
    idle_cycle();
    check_capture("imm_armed", 2'd1, 5'd0, 1'b0);
    retire_pc(8'h2A, 8'h5E);
    idle_cycle();
    check_capture("imm_readout", 2'd3, 5'd1, 1'b1);
    drain(0, "imm");
  endtask

  initial begin
    test_reset();
    test_pc_trigger();
    test_wrap();
    test_backpressure();
    test_reset_mid_post();
    test_immediate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameter PC_W, default 8, program-counter width.
REQ-002 Parameter INSTR_W, default 8, instruction width.
REQ-003 Parameter DATA_W, default 8, write-back data width.
REQ-004 Parameter DEPTH, default 16, trace entries; power of two, >= 4; AW = log2(DEPTH).
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 arm  in  1  single-cycle request to start a capture.
REQ-008 trig_mode  in  2  00 PC match, 01 instr match, 10 PC and instr match, 11 immediate.
REQ-009 trig_pc  in  PC_W  PC trigger value.
REQ-010 trig_instr  in  INSTR_W  instruction trigger value.
REQ-011 post_count  in  AW  entries to capture after the trigger entry.
REQ-012 retire  in  1  one instruction retired this cycle; qualifies pc/instr/wb_data.
REQ-013 pc, instr, wb_data  in  PC_W, INSTR_W, DATA_W  retired-instruction sample.
REQ-014 rd_ready  in  1  consumer accepts rd_data.
REQ-015 rd_valid  out  1  rd_data holds an unread entry.
REQ-016 rd_data  out  PC_W+INSTR_W+DATA_W  {pc, instr, wb_data}, pc in MSBs.
REQ-017 state  out  2  IDLE=0, ARMED=1, POST=2, READOUT=3.
REQ-018 triggered  out  1  trigger seen in current capture.
REQ-019 count  out  AW+1  valid entries held, 0..DEPTH.
REQ-020 done  out  1  one-cycle pulse when last entry is read.

Function
REQ-021 IDLE: retire ignored; arm -> ARMED, write pointer=0, count=0, triggered=0.
REQ-022 ARMED/POST: each retire writes one entry at write pointer on that edge; pointer wraps mod DEPTH; count increments, saturating at DEPTH (oldest entry overwritten).
REQ-023 Trigger in ARMED only: retire and trig_mode condition true; triggering entry is stored; triggered=1 next cycle; post_count latched.
REQ-024 Trigger with latched post_count=0 -> READOUT; else -> POST with remaining=post_count.
REQ-025 POST: each retire writes and decrements remaining; the write making remaining 0 -> READOUT.
REQ-026 arm in ARMED or POST restarts the capture as in REQ-021; arm in READOUT is ignored; arm and retire in the same IDLE cycle captures nothing.
REQ-027 READOUT: retire ignored; read pointer starts at oldest entry (write pointer - count mod DEPTH); rd_valid = (count != 0).
REQ-028 Transfer on rd_valid and rd_ready: read pointer advances mod DEPTH, count decrements; rd_data and rd_valid stable while rd_valid and not rd_ready.
REQ-029 Transfer making count 0 -> IDLE and done=1 for that next cycle; triggered clears on entering IDLE.
REQ-030 Zero-latency read: rd_data reflects the read-pointer entry in the same cycle; a write is visible in count the cycle after its edge.

Reset
REQ-031 reset low at clk edge: state=IDLE, pointers=0, count=0, remaining=0, triggered=0, done=0, rd_valid=0; memory contents not reset.
REQ-032 Reset in any state, including POST or mid-READOUT, aborts the capture; no entry is readable afterwards.

Structure
REQ-033 Shared package cpu_dbg_pkg holds the state encoding, trig_mode encoding and rd_data field offsets.
REQ-034 Single sub-module trace_mem: DEPTH x (PC_W+INSTR_W+DATA_W), synchronous write, asynchronous read, no reset.

Verification (DEPTH=16)
REQ-035 Reset held low 2 cycles -> state=0, count=0, rd_valid=0, triggered=0, done=0.
REQ-036 Arm, mode 00, trig_pc=8'h04, post_count=2, retire PC 00..09 with instr 8'h1A at PC 04 -> READOUT after PC 06; 7 entries read with PC 00..06 in order; done pulses once.
REQ-037 Wrap: mode 00, trig_pc=8'h1C, post_count=3, retire PC 00..1F -> count=16; readout PC 10..1F.
REQ-038 Backpressure: rd_ready toggled 1,0,0,1,... during readout -> rd_data constant while stalled; no entry lost or duplicated.
REQ-039 Reset low mid-POST (after 5 post-trigger retires of 8) -> state=0, count=0, rd_valid=0 next cycle.
REQ-040 Mode 11, post_count=0, arm then one retire PC 8'h2A -> count=1; single readout of PC 2A; arm in the same cycle as a retire in IDLE captures nothing.
